prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 32 +++
 rtl/prog_loader_word_packer.sv | 51 +++++
 rtl/prog_loader.sv | 177 +++++++++++++++++
 tb/tb_prog_loader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared state encoding, error codes and frame-size constants
//               for the program loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prog_loader_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_HDR_HI = 4'd1,
      S_HDR_LO = 4'd2,
      S_DATA   = 4'd3,
      S_WRITE  = 4'd4,
      S_CSUM   = 4'd5,
      S_DONE   = 4'd6,
      S_ERROR  = 4'd7
   } state_t;

   localparam logic [1:0] c_err_none    = 2'b00;
   localparam logic [1:0] c_err_count   = 2'b01;
   localparam logic [1:0] c_err_csum    = 2'b10;
   localparam logic [1:0] c_err_timeout = 2'b11;

   localparam int HDR_BYTES  = 2;
   localparam int WORD_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/prog_loader_word_packer.sv
// ============================================================================
// Module      : word_packer
// Description : Big-endian 8-to-32 shift register with byte counter, running
//               XOR checksum and a one-cycle word_full flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_packer
   import prog_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic [7:0]  csum,
   output logic        last_byte,
   output logic        word_full
);

   logic [1:0]  r_cnt;
   logic [31:0] r_word;
   logic [7:0]  r_csum;
   logic        r_full;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_cnt  <= 2'd0;
         r_word <= 32'd0;
         r_csum <= 8'd0;
         r_full <= 1'b0;
      end else if (byte_en) begin
         r_word <= {r_word[23:0], byte_in};
         r_csum <= r_csum ^ byte_in;
         r_cnt  <= r_cnt + 2'd1;
         r_full <= (r_cnt == 2'(WORD_BYTES - 1));
      end else begin
         r_full <= 1'b0;
      end
   end

   assign word      = r_word;
   assign csum      = r_csum;
   assign last_byte = (r_cnt == 2'(WORD_BYTES - 1));
   assign word_full = r_full;

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// Module      : prog_loader
// Description : Receives a counted, checksummed byte frame and writes it as
//               32-bit words into instruction memory while holding the CPU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = 1000000
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_code
);

   localparam int          c_tmo_w     = $clog2(TIMEOUT + 1);
   localparam logic [31:0] c_max_words = 32'd1 << ADDR_W;

   state_t               r_state, w_next;
   logic [15:0]          r_count;
   logic [ADDR_W:0]      r_word_idx;
   logic [c_tmo_w-1:0]   r_idle;
   logic [1:0]           r_err_code, w_err_code;
   logic                 w_ready, w_accept, w_clear, w_pk_en, w_timeout;
   logic                 w_bad_count, w_last_word;
   logic [15:0]          w_n;
   logic [31:0]          w_word;
   logic [7:0]           w_csum;
   logic                 w_last_byte, w_full;

   word_packer u_packer (
      .clk       (CLK),
      .rst       (reset),
      .clear     (w_clear),
      .byte_en   (w_pk_en),
      .byte_in   (byte_data),
      .word      (w_word),
      .csum      (w_csum),
      .last_byte (w_last_byte),
      .word_full (w_full)
   );

   assign w_ready  = (r_state == S_HDR_HI) || (r_state == S_HDR_LO) ||
                     (r_state == S_DATA)   || (r_state == S_CSUM);
   assign w_accept = byte_valid && w_ready;

   // A stall of TIMEOUT consecutive ready-but-idle cycles aborts the load.
   assign w_timeout   = !w_accept && (32'(r_idle) == 32'(TIMEOUT - 1));
   assign w_n         = {r_count[15:8], byte_data};
   assign w_bad_count = (w_n == 16'd0) || (32'(w_n) > c_max_words);
   assign w_last_word = (32'(r_word_idx) + 32'd1 == 32'(r_count));

   always_ff @(posedge CLK) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_err_code = r_err_code;
      w_clear    = 1'b0;
      w_pk_en    = 1'b0;
      mem_we     = 1'b0;
      busy       = 1'b0;
      cpu_hold   = 1'b1;
      case (r_state)
         S_IDLE, S_DONE, S_ERROR: begin
            cpu_hold = (r_state != S_DONE);
            if (start) begin
               w_next     = S_HDR_HI;
               w_clear    = 1'b1;
               w_err_code = c_err_none;
            end
         end
         S_HDR_HI: begin
            busy = 1'b1;
            if (w_accept) begin
               w_next = S_HDR_LO;
            end else if (w_timeout) begin
               w_next     = S_ERROR;
               w_err_code = c_err_timeout;
            end
         end
         S_HDR_LO: begin
            busy = 1'b1;
            if (w_accept) begin
               if (w_bad_count) begin
                  w_next     = S_ERROR;
                  w_err_code = c_err_count;
               end else begin
                  w_next = S_DATA;
               end
            end else if (w_timeout) begin
               w_next     = S_ERROR;
               w_err_code = c_err_timeout;
            end
         end
         S_DATA: begin
            busy = 1'b1;
            if (w_accept) begin
               w_pk_en = 1'b1;
               if (w_last_byte) w_next = S_WRITE;
            end else if (w_timeout) begin
               w_next     = S_ERROR;
               w_err_code = c_err_timeout;
            end
         end
         S_WRITE: begin
            busy   = 1'b1;
            mem_we = w_full;
            w_next = w_last_word ? S_CSUM : S_DATA;
         end
         S_CSUM: begin
            busy = 1'b1;
            if (w_accept) begin
               if (byte_data == w_csum) begin
                  w_next = S_DONE;
               end else begin
                  w_next     = S_ERROR;
                  w_err_code = c_err_csum;
               end
            end else if (w_timeout) begin
               w_next     = S_ERROR;
               w_err_code = c_err_timeout;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         r_count    <= 16'd0;
         r_word_idx <= '0;
         r_idle     <= '0;
         r_err_code <= c_err_none;
      end else begin
         r_err_code <= w_err_code;
         if (w_clear) begin
            r_count    <= 16'd0;
            r_word_idx <= '0;
            r_idle     <= '0;
         end else begin
            if (w_accept && r_state == S_HDR_HI) r_count[15:8] <= byte_data;
            if (w_accept && r_state == S_HDR_LO) r_count[7:0]  <= byte_data;
            if (mem_we)        r_word_idx <= r_word_idx + 1'b1;
            if (w_accept)      r_idle     <= '0;
            else if (w_ready)  r_idle     <= r_idle + 1'b1;
         end
      end
   end

   assign byte_ready = w_ready;
   assign mem_addr   = r_word_idx[ADDR_W-1:0];
   assign mem_wdata  = w_word;
   assign done       = (r_state == S_DONE);
   assign error      = (r_state == S_ERROR);
   assign err_code   = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader: table of frames plus
//               timeout, reset-abort and full-memory sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_loader;

   localparam int ADDR_W  = 10;
   localparam int TIMEOUT = 40;

   logic              CLK = 1'b0;
   logic              reset, start, byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready, mem_we, cpu_hold, busy, done, error;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [1:0]        err_code;

   int checks   = 0;
   int failures = 0;
   int writes   = 0;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;
   wr_t exp_q[$];

   typedef struct {
      logic [15:0] n;
      logic [31:0] w0;
      logic [31:0] w1;
      logic        force_cs;
      logic [7:0]  cs_val;
      int          stall;
      logic        mid_start;
      logic        exp_done;
      logic [1:0]  exp_err;
   } vec_t;
   vec_t vecs[7];

   prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .CLK        (CLK),
      .reset      (reset),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .err_code   (err_code)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Write monitor: every strobe must match the oldest expected word.
   always @(negedge CLK) begin
      if (!reset && mem_we) begin
         writes++;
         check("ready_in_write", {63'd0, byte_ready}, 64'd0);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=%0h:%0h expected=none", mem_addr, mem_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", {54'd0, mem_addr}, {54'd0, e.addr});
            check("wr_data", {32'd0, mem_wdata}, {32'd0, e.data});
         end
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int stall_pct);
      bit acc;
      int guard;
      for (int s = 0; s < 3; s++) begin
         if (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
            byte_valid = 1'b0;
            @(posedge CLK); #1;
         end
      end
      byte_valid = 1'b1;
      byte_data  = b;
      acc   = 1'b0;
      guard = 0;
      while (!acc) begin
         @(negedge CLK);
         acc = byte_ready;
         @(posedge CLK); #1;
         guard++;
         if (!acc && guard > 100) begin
            check("accept_bound", 64'd0, 64'd1);
            byte_valid = 1'b0;
            return;
         end
      end
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      @(negedge CLK);
      while (busy && guard < 200) begin
         @(negedge CLK);
         guard++;
      end
      if (busy) check("wait_idle_bound", {63'd0, busy}, 64'd0);
   endtask

   task automatic run_frame(input logic [15:0] n, input logic [31:0] w0, input logic [31:0] w1,
                            input logic force_cs, input logic [7:0] cs_val,
                            input int stall_pct, input logic mid_start);
      logic [31:0] w;
      logic [7:0]  cs;
      wr_t         e;
      bit          bad;
      bad = (n == 16'd0) || (int'(n) > (1 << ADDR_W));
      cs  = 8'd0;
      pulse_start();
      send_byte(n[15:8], stall_pct);
      send_byte(n[7:0], stall_pct);
      if (!bad) begin
         if (mid_start) begin
            byte_valid = 1'b0;
            pulse_start();
         end
         for (int i = 0; i < int'(n); i++) begin
            w = (i == 0) ? w0 : (i == 1) ? w1 : $urandom();
            for (int b = 3; b >= 0; b--) begin
               send_byte(w[b*8 +: 8], stall_pct);
               cs = cs ^ w[b*8 +: 8];
            end
            e.addr = ADDR_W'(i);
            e.data = w;
            exp_q.push_back(e);
         end
         send_byte(force_cs ? cs_val : cs, stall_pct);
      end
      byte_valid = 1'b0;
   endtask

   task automatic check_end(input string tag, input logic exp_done, input logic [1:0] exp_err, input int exp_writes);
      check({tag, "_done"},     {63'd0, done},     {63'd0, exp_done});
      check({tag, "_error"},    {63'd0, error},    {63'd0, !exp_done});
      check({tag, "_err_code"}, {62'd0, err_code}, {62'd0, exp_err});
      check({tag, "_cpu_hold"}, {63'd0, cpu_hold}, {63'd0, !exp_done});
      check({tag, "_writes"},   64'(writes),       64'(exp_writes));
      check({tag, "_pending"},  64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int nw;
      reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'd0;

      //            n        w0            w1            fcs  csv    stall ms   done err
      vecs[0] = '{16'd2,    32'h20080005, 32'hAC080000, 1'b0, 8'h00, 0,  1'b0, 1'b1, 2'b00};
      vecs[1] = '{16'd0,    32'h0,        32'h0,        1'b0, 8'h00, 0,  1'b0, 1'b0, 2'b01};
      vecs[2] = '{16'd1,    32'h12345678, 32'h0,        1'b1, 8'h00, 0,  1'b0, 1'b0, 2'b10};
      vecs[3] = '{16'd1025, 32'h0,        32'h0,        1'b0, 8'h00, 0,  1'b0, 1'b0, 2'b01};
      vecs[4] = '{16'hFFFF, 32'h0,        32'h0,        1'b0, 8'h00, 20, 1'b0, 1'b0, 2'b01};
      vecs[5] = '{16'd1,    32'hFFFFFFFF, 32'h0,        1'b0, 8'h00, 0,  1'b0, 1'b1, 2'b00};
      vecs[6] = '{16'd5,    32'hDEADBEEF, 32'h01020304, 1'b0, 8'h00, 30, 1'b1, 1'b1, 2'b00};

      repeat (3) @(posedge CLK);
      #1 reset = 1'b0;
      @(negedge CLK);
      check("reset_outputs",
            {14'd0, byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error, err_code},
            {14'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00});
      @(posedge CLK); #1;

      for (int v = 0; v < 7; v++) begin
         writes = 0;
         run_frame(vecs[v].n, vecs[v].w0, vecs[v].w1, vecs[v].force_cs, vecs[v].cs_val,
                   vecs[v].stall, vecs[v].mid_start);
         wait_idle();
         nw = (vecs[v].exp_err == 2'b01) ? 0 : int'(vecs[v].n);
         check_end($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err, nw);
         @(posedge CLK); #1;
      end

      // Stall after the fifth data byte until the idle limit expires.
      begin
         wr_t e;
         int guard;
         writes = 0;
         pulse_start();
         send_byte(8'h00, 0);
         send_byte(8'h03, 0);
         e.addr = '0; e.data = 32'h11223344;
         for (int b = 3; b >= 0; b--) send_byte(e.data[b*8 +: 8], 0);
         exp_q.push_back(e);
         send_byte(8'h55, 0);
         byte_valid = 1'b0;
         repeat (TIMEOUT - 5) @(negedge CLK);
         check("tmo_not_early", {63'd0, error}, 64'd0);
         guard = 0;
         while (!error && guard < 20) begin
            @(negedge CLK);
            guard++;
         end
         check_end("tmo", 1'b0, 2'b11, 1);
         @(posedge CLK); #1;
      end

      // Reset lands on the third data byte; a fresh load must start clean.
      writes = 0;
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      send_byte(8'hA1, 0);
      send_byte(8'hA2, 0);
      byte_valid = 1'b1;
      byte_data  = 8'hA3;
      reset      = 1'b1;
      @(posedge CLK); #1;
      reset      = 1'b0;
      byte_valid = 1'b0;
      @(negedge CLK);
      check("abort_outputs",
            {14'd0, byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error, err_code},
            {14'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00});
      @(posedge CLK); #1;
      run_frame(16'd1, 32'hCAFEF00D, 32'h0, 1'b0, 8'h00, 0, 1'b0);
      wait_idle();
      check_end("after_abort", 1'b1, 2'b00, 1);
      @(posedge CLK); #1;

      // Fill the whole memory with random words under random valid gaps.
      writes = 0;
      run_frame(16'd1024, $urandom(), $urandom(), 1'b0, 8'h00, 25, 1'b0);
      wait_idle();
      check_end("full_mem", 1'b1, 2'b00, 1024);

      repeat (2) @(posedge CLK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
